input_handshake: RTL
====================

Name: input_handshake

Overview:
- Handshake unit on the user-input side of the processor: the receiving end of the inp request that the control unit issues for an input instruction.
- On an inp request it freezes the CPU clock divider through halt.
- It waits for a debounced confirm-button press-and-release, latches the switch value, releases halt and presents the value to the extender.
- Runs on the undivided board clock, so it stays alive while the CPU clock is halted.

Parameters:
- DATA_WIDTH, 18, width of switch bus and latched value.
- DEBOUNCE_CYCLES, 250000, consecutive stable clock cycles needed to accept a key level change (5 ms at 50 MHz); minimum 1.

Ports:
- clock  input  1  board clock (50 MHz), all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- inp_req  input  1  input-instruction request from the control unit; level, held while the instruction is current.
- sw  input  DATA_WIDTH  raw switch levels, treated as quasi-static.
- key_n  input  1  raw confirm button, active-low, asynchronous, bouncy.
- halt  output  1  registered; 1 freezes the CPU clock divider.
- data_out  output  DATA_WIDTH  registered; last accepted switch value.
- data_valid  output  1  registered; one-cycle pulse when a new value is accepted.
- busy  output  1  registered; 1 in any state other than IDLE.

Behaviour:
- Reset values: halt=0, data_out=0, data_valid=0, busy=0, state=IDLE.
  - Sync flops = 1; debounced key key_db = 1 (released); debounce counter = 0.
  - Reset wins over every other event, including mid-handshake; halt drops the cycle after reset is sampled.
- Synchronizer: 2-flop chain on key_n giving key_s. No other input is synchronized; sw is sampled only at the latch instant.
- Debouncer:
  - Counter increments each cycle key_s != key_db, and clears to 0 whenever key_s == key_db.
  - key_db toggles to key_s on the edge where the counter reaches DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES consecutive differing samples; the counter clears at the same edge.
  - A glitch shorter than DEBOUNCE_CYCLES never changes key_db.
  - press_ev = key_db 1->0 transition; release_ev = key_db 0->1 transition. Each is a one-cycle internal strobe.
  - Worst-case key_n-to-key_db latency is 2+DEBOUNCE_CYCLES cycles.
- FSM states and transitions:
  - IDLE: inp_req=1 -> WAIT_PRESS, halt=1 and busy=1 from the next cycle.
  - WAIT_PRESS: on press_ev -> data_out <= sw sampled that cycle, go to WAIT_RELEASE.
    - If key_db is already 0 on entry, the operator must release and press again; only a 1->0 transition counts.
  - WAIT_RELEASE: on release_ev -> halt <= 0, data_valid <= 1 (one cycle), go to DONE.
    - sw changes in this state do not affect data_out.
  - DONE: remain until inp_req=0, then -> IDLE.
    - Prevents a still-high inp_req from re-arming, because the CPU clock needs divider cycles to advance.
    - Further presses in DONE or IDLE are ignored; data_out holds.
- inp_req dropping in WAIT_PRESS or WAIT_RELEASE is ignored; the handshake completes normally. The CPU is halted, so this is a protocol error.
- data_valid is 0 in every cycle except the single cycle after the release_ev edge.
- Back-to-back input instructions: inp_req low for at least one clock then high again re-arms from IDLE.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle: reset=1 for 2 cycles, key_n=1 -> halt=0, data_out=0, data_valid=0, busy=0.
- Basic handshake: inp_req=1 -> halt=1 the next cycle.
  - sw=18'h00123, clean key_n low for 10 cycles then high -> data_out=18'h00123 latched 6 cycles after key_n fell.
  - halt falls and data_valid pulses exactly once, 6 cycles after key_n rose.
  - inp_req=0 -> busy=0.
- Bounce rejection: in WAIT_PRESS, key_n low for 3 cycles, high 2, low 3, high 2 -> no latch, halt stays 1.
  - A following 8-cycle clean press latches sw.
- Key held at request: key_n=0 stable, then inp_req=1 -> no latch.
  - Release, then press with sw=18'h3FFFF -> data_out=18'h3FFFF.
- sw change after press: press with sw=18'h00005, then change sw to 18'h0000A before release -> data_out=18'h00005 after data_valid.
- Reset mid-operation: assert reset in WAIT_RELEASE -> next cycle halt=0, busy=0, data_valid=0, data_out=0.
  - With inp_req held 1 afterwards, the block re-enters WAIT_PRESS.

Source files
------------

// File: rtl/input_handshake.sv
// Operator-input handshake: halts the CPU clock on an input request, waits
// for a debounced confirm press/release, latches the switches, then resumes.
module input_handshake #(
  parameter int DATA_WIDTH      = 18,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inp_req,
  input  logic [DATA_WIDTH-1:0] sw,
  input  logic                  key_n,
  output logic                  halt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             key_meta;
  logic             key_s;
  logic             key_db;
  logic [CNT_W-1:0] db_cnt;
  logic             db_flip;
  logic             press_ev;
  logic             release_ev;
  logic             latch_en;
  logic             valid_next;

  // Two-flop synchronizer for the asynchronous button; idles released (1).
  always_ff @(posedge clock) begin
    if (reset) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
    end
  end

  // The debounced level flips on the edge that completes a run of
  // DEBOUNCE_CYCLES consecutive differing samples; the strobes mark that edge
  // so the FSM acts in the same cycle key_db changes.
  assign db_flip    = (key_s != key_db) && (db_cnt == CNT_LAST);
  assign press_ev   = db_flip &  key_db;
  assign release_ev = db_flip & ~key_db;

  // Debounce counter and debounced key level.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_db <= 1'b1;
      db_cnt <= '0;
    end else if (key_s == key_db) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      key_db <= key_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Next-state logic; inp_req is ignored once the handshake has started
  // because the halted CPU cannot legitimately withdraw it.
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    valid_next = 1'b0;
    case (state)
      IDLE: begin
        if (inp_req) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (press_ev) begin
          latch_en   = 1'b1;
          state_next = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (release_ev) begin
          valid_next = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // Stay until the request drops so a lingering inp_req cannot re-arm.
        if (!inp_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      halt       <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      state      <= state_next;
      halt       <= (state_next == WAIT_PRESS) || (state_next == WAIT_RELEASE);
      busy       <= (state_next != IDLE);
      data_valid <= valid_next;
      if (latch_en) data_out <= sw;
    end
  end

endmodule
